// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pixel type and helpers
package vga_pkg;

  // Default 640x480@60 timing, in pixel clocks / lines
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Frame-buffer geometry
  localparam int IMG_W_DEF      = 160;
  localparam int SCALE_LOG2_DEF = 2;
  localparam int ADDR_W         = 16;

  // Counter width: enough for 0..V_TOTAL-1 and 0..H_TOTAL-1
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Inclusive range test on a counter value
  function automatic logic in_range(input logic [CNT_W-1:0] x, input int lo, input int hi);
    return (int'(x) >= lo) && (int'(x) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, raw sync and active-region flag
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS  = H_ACTIVE + H_FP;
  localparam int H_SE  = H_SS + H_SYNC - 1;
  localparam int V_SS  = V_ACTIVE + V_FP;
  localparam int V_SE  = V_SS + V_SYNC - 1;

  logic             run;
  logic [CNT_W-1:0] h_ctr;
  logic [CNT_W-1:0] v_ctr;

  // Raster counters: parked at (0,0) while disabled; the first enabled edge
  // only arms run so that (0,0) is presented for a full clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      h_ctr <= '0;
      v_ctr <= '0;
    end else if (!enable) begin
      run   <= 1'b0;
      h_ctr <= '0;
      v_ctr <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_ctr == CNT_W'(H_TOT - 1)) begin
          h_ctr <= '0;
          if (v_ctr == CNT_W'(V_TOT - 1)) begin
            v_ctr <= '0;
          end else begin
            v_ctr <= v_ctr + 1'b1;
          end
        end else begin
          h_ctr <= h_ctr + 1'b1;
        end
      end
    end
  end

  // Registered raster state with its decoded sync and active flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      active <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else if (!enable || !run) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      active <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else begin
      h_cnt  <= h_ctr;
      v_cnt  <= v_ctr;
      active <= (int'(h_ctr) < H_ACTIVE) && (int'(v_ctr) < V_ACTIVE);
      hsync  <= !in_range(h_ctr, H_SS, H_SE);
      vsync  <= !in_range(v_ctr, V_SS, V_SE);
    end
  end

endmodule

// File: rtl/vga_controller.sv
// rtl/vga_controller.sv - 640x480 VGA output streaming a 4x upscaled frame buffer
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic              CLK_25_I,
  input  logic              RST_N_I,
  input  logic              ENABLE_I,
  input  logic [11:0]       VIDEO_PXL_I,
  output logic [3:0]        RED_O,
  output logic [3:0]        GREEN_O,
  output logic [3:0]        BLUE_O,
  output logic              HSYNC_O,
  output logic              VSYNC_O,
  output logic              VIDEO_EN_O,
  output logic [ADDR_W-1:0] ADDRESS_O
);

  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              active;
  logic              hsync_raw;
  logic              vsync_raw;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_next;
  logic              hsync_d1;
  logic              vsync_d1;
  rgb444_t           pxl;
  rgb444_t           rgb_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (CLK_25_I),
    .rst_n  (RST_N_I),
    .enable (ENABLE_I),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hsync  (hsync_raw),
    .vsync  (vsync_raw)
  );

  assign pxl       = VIDEO_PXL_I;
  assign addr_next = row_base + ADDR_W'(h_cnt >> SCALE_LOG2);

  // Row base tracks (v_cnt >> SCALE_LOG2) * IMG_W: step by one image row each
  // time a group of scaled lines completes, restart at the top of the frame.
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      row_base <= '0;
    end else if (!ENABLE_I) begin
      row_base <= '0;
    end else if (h_cnt == CNT_W'(H_TOT - 1)) begin
      if (v_cnt == CNT_W'(V_TOT - 1)) begin
        row_base <= '0;
      end else if (&v_cnt[SCALE_LOG2-1:0]) begin
        row_base <= row_base + ADDR_W'(IMG_W);
      end
    end
  end

  // Stage 1: frame-buffer address and active flag, syncs delayed to match
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ADDRESS_O  <= '0;
      VIDEO_EN_O <= 1'b0;
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
    end else if (!ENABLE_I) begin
      ADDRESS_O  <= '0;
      VIDEO_EN_O <= 1'b0;
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
    end else begin
      ADDRESS_O  <= active ? addr_next : '0;
      VIDEO_EN_O <= active;
      hsync_d1   <= hsync_raw;
      vsync_d1   <= vsync_raw;
    end
  end

  // Stage 2: capture the BRAM word for the previous address, blank otherwise
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      rgb_q   <= '0;
      HSYNC_O <= 1'b1;
      VSYNC_O <= 1'b1;
    end else if (!ENABLE_I) begin
      rgb_q   <= '0;
      HSYNC_O <= 1'b1;
      VSYNC_O <= 1'b1;
    end else begin
      rgb_q   <= VIDEO_EN_O ? pxl : '0;
      HSYNC_O <= hsync_d1;
      VSYNC_O <= vsync_d1;
    end
  end

  assign RED_O   = rgb_q.r;
  assign GREEN_O = rgb_q.g;
  assign BLUE_O  = rgb_q.b;

endmodule

// File: tb/tb_vga_controller.sv
// tb/tb_vga_controller.sv - directed self-checking bench for vga_controller
module tb_vga_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a;
  logic        en_b;
  logic [11:0] pxl;
  logic        sel;

  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, ve_a, hs_b, vs_b, ve_b;
  logic [15:0] addr_a, addr_b;

  logic        obs_en, obs_hs, obs_vs;
  logic [15:0] obs_addr;
  logic [11:0] obs_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] addr_log[$];
  bit          en_log[$];
  bit          hs_log[$];
  bit          vs_log[$];
  int          err_en, err_addr, err_hs, err_vs, err_rgb, max_addr;

  always #20 clk = ~clk;

  vga_controller u_a (
    .CLK_25_I(clk), .RST_N_I(rst_n), .ENABLE_I(en_a), .VIDEO_PXL_I(pxl),
    .RED_O(r_a), .GREEN_O(g_a), .BLUE_O(b_a), .HSYNC_O(hs_a), .VSYNC_O(vs_a),
    .VIDEO_EN_O(ve_a), .ADDRESS_O(addr_a)
  );

  // Narrow-line instance: full vertical timing in a short frame (48 x 525)
  vga_controller #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4), .IMG_W(8)) u_b (
    .CLK_25_I(clk), .RST_N_I(rst_n), .ENABLE_I(en_b), .VIDEO_PXL_I(pxl),
    .RED_O(r_b), .GREEN_O(g_b), .BLUE_O(b_b), .HSYNC_O(hs_b), .VSYNC_O(vs_b),
    .VIDEO_EN_O(ve_b), .ADDRESS_O(addr_b)
  );

  always_comb begin
    obs_en   = sel ? ve_b : ve_a;
    obs_hs   = sel ? hs_b : hs_a;
    obs_vs   = sel ? vs_b : vs_a;
    obs_addr = sel ? addr_b : addr_a;
    obs_rgb  = sel ? {r_b, g_b, b_b} : {r_a, g_a, b_a};
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Enable the selected instance and compare every cycle against a raster model
  task automatic run_frame(input int ncyc, input int hact, input int htot,
                           input int hs0, input int hs1, input int imgw);
    int          s, h, v;
    logic        en_e, hs_e, vs_e, prev_en;
    logic [15:0] addr_e;
    logic [11:0] prev_pxl;
    addr_log.delete(); en_log.delete(); hs_log.delete(); vs_log.delete();
    err_en = 0; err_addr = 0; err_hs = 0; err_vs = 0; err_rgb = 0; max_addr = 0;
    @(negedge clk);
    prev_en  = obs_en;
    prev_pxl = pxl;
    if (sel) en_b = 1'b1; else en_a = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      s = c - 2; en_e = 1'b0; addr_e = 16'd0;
      if (s >= 0) begin
        h = s % htot; v = (s / htot) % 525;
        if (h < hact && v < 480) begin
          en_e = 1'b1;
          addr_e = 16'((v / 4) * imgw + h / 4);
        end
      end
      s = c - 3; hs_e = 1'b1; vs_e = 1'b1;
      if (s >= 0) begin
        h = s % htot; v = (s / htot) % 525;
        hs_e = !(h >= hs0 && h <= hs1);
        vs_e = !(v >= 490 && v <= 491);
      end
      if (obs_en !== en_e) err_en++;
      if (obs_addr !== addr_e) err_addr++;
      if (obs_hs !== hs_e) err_hs++;
      if (obs_vs !== vs_e) err_vs++;
      if (obs_rgb !== (prev_en ? prev_pxl : 12'd0)) err_rgb++;
      addr_log.push_back(obs_addr);
      en_log.push_back(obs_en);
      hs_log.push_back(obs_hs);
      vs_log.push_back(obs_vs);
      if (int'(obs_addr) > max_addr) max_addr = int'(obs_addr);
      prev_en  = obs_en;
      pxl      = 12'($urandom);
      prev_pxl = pxl;
    end
  endtask

  task automatic check_traces(input string pfx);
    check_eq({pfx, "_en_trace_errs"}, err_en, 0);
    check_eq({pfx, "_addr_trace_errs"}, err_addr, 0);
    check_eq({pfx, "_hsync_trace_errs"}, err_hs, 0);
    check_eq({pfx, "_vsync_trace_errs"}, err_vs, 0);
    check_eq({pfx, "_rgb_trace_errs"}, err_rgb, 0);
  endtask

  initial begin
    int dev, cnt;
    sel = 1'b0; rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; pxl = 12'd0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hsync", hs_a, 1);
    check_eq("rst_vsync", vs_a, 1);
    check_eq("rst_rgb", {r_a, g_a, b_a}, 0);
    check_eq("rst_video_en", ve_a, 0);
    check_eq("rst_address", addr_a, 0);

    rst_n = 1'b1;
    dev = 0;
    repeat (1000) begin
      @(posedge clk);
      @(negedge clk);
      pxl = 12'($urandom);
      if (ve_a !== 1'b0 || addr_a !== 16'd0 || {r_a, g_a, b_a} !== 12'd0 || hs_a !== 1'b1 || vs_a !== 1'b1) dev++;
      if (ve_b !== 1'b0 || addr_b !== 16'd0 || {r_b, g_b, b_b} !== 12'd0 || hs_b !== 1'b1 || vs_b !== 1'b1) dev++;
    end
    check_eq("idle_deviations", dev, 0);

    // Full-size instance: first eight lines plus a little of line 8
    run_frame(6500, 640, 800, 656, 751, 160);
    check_traces("a");
    check_eq("a_en_edge1", en_log[1], 0);
    check_eq("a_en_edge2", en_log[2], 1);
    check_eq("a_addr_px3", addr_log[5], 0);
    check_eq("a_addr_px4", addr_log[6], 1);
    check_eq("a_addr_line0_end", addr_log[2 + 639], 159);
    check_eq("a_en_after_line0", en_log[2 + 640], 0);
    check_eq("a_addr_line1_start", addr_log[2 + 800], 0);
    check_eq("a_addr_line3_end", addr_log[2 + 2400 + 639], 159);
    check_eq("a_addr_line4_start", addr_log[2 + 3200], 160);
    check_eq("a_addr_line7_end", addr_log[2 + 5600 + 639], 319);
    cnt = 0;
    for (int i = 2; i < 802; i++) cnt += int'(en_log[i]);
    check_eq("a_en_per_line", cnt, 640);
    cnt = 0;
    for (int i = 3; i < 803; i++) cnt += int'(!hs_log[i]);
    check_eq("a_hsync_low_clocks", cnt, 96);
    check_eq("a_hsync_before_fall", hs_log[3 + 655], 1);
    check_eq("a_hsync_fall", hs_log[3 + 656], 0);
    check_eq("a_hsync_rise", hs_log[3 + 752], 1);
    check_eq("a_pre_drop_en", ve_a, 1);

    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("drop_video_en", ve_a, 0);
    check_eq("drop_address", addr_a, 0);
    check_eq("drop_rgb", {r_a, g_a, b_a}, 0);
    check_eq("drop_hsync", hs_a, 1);

    run_frame(60, 640, 800, 656, 751, 160);
    check_traces("restart");
    check_eq("restart_en_edge1", en_log[1], 0);
    check_eq("restart_addr0", addr_log[2], 0);
    check_eq("restart_addr_px4", addr_log[6], 1);

    check_eq("pre_async_en", ve_a, 1);
    #5 rst_n = 1'b0;
    #1;
    check_eq("async_video_en", ve_a, 0);
    check_eq("async_address", addr_a, 0);
    check_eq("async_rgb", {r_a, g_a, b_a}, 0);
    check_eq("async_hsync", hs_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow-line instance: whole frame plus the start of the next one
    sel = 1'b1;
    run_frame(48733, 32, 48, 36, 43, 8);
    check_traces("b");
    check_eq("b_max_address", max_addr, 959);
    check_eq("b_addr_line479_end", addr_log[2 + 479 * 48 + 31], 959);
    check_eq("b_hsync_fall", hs_log[3 + 36], 0);
    check_eq("b_hsync_rise", hs_log[3 + 44], 1);
    cnt = 0;
    for (int i = 3; i < 3 + 25200; i++) cnt += int'(!vs_log[i]);
    check_eq("b_vsync_low_clocks", cnt, 96);
    check_eq("b_vsync_before_fall", vs_log[3 + 23520 - 1], 1);
    check_eq("b_vsync_fall", vs_log[3 + 23520], 0);
    check_eq("b_vsync_period_prev", vs_log[3 + 23520 + 25200 - 1], 1);
    check_eq("b_vsync_period_fall", vs_log[3 + 23520 + 25200], 0);
    check_eq("b_frame2_addr0", addr_log[2 + 25200], 0);
    check_eq("b_frame2_en", en_log[2 + 25200], 1);
    check_eq("b_frame2_line4", addr_log[2 + 25200 + 192], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
